// File: rtl/fine_tdc_decoder.sv
// -----------------------------------------------------------------------------
// fine_tdc_decoder
//
// Receiving end of the fine TDC delay line. Each clock the latched thermometer
// word from the delay line is registered. A rising edge on tap 0 marks a hit.
// Single-bit bubbles are removed with a 3-tap majority vote, and the cleaned word
// is converted to a binary ones-count (the fine code). Each hit is paired with
// the free-running coarse count that was current on the sampling edge. The
// {coarse,fine} timestamp is then presented on a valid/ready port.
//
// Parameters
//   STAGES    delay-line taps (width of i_thermo, bit 0 = first tap)
//   COARSE_W  coarse counter / o_ts_coarse width
//   FINE_W    o_ts_fine width, needs 2**FINE_W > STAGES
//
// Ports
//   i_clk        single clock (the fine_tdc stop clock)
//   i_reset      asynchronous active-high reset
//   i_thermo     latched thermometer word from fine_tdc
//   i_arm        level enable for hit capture
//   i_ts_ready   downstream accepts the current timestamp
//   o_ts_valid   timestamp valid
//   o_ts_coarse  coarse count at the sampling edge of the hit
//   o_ts_fine    bubble-corrected ones-count, 0..STAGES
//   o_overflow   sticky flag: at least one hit was dropped while holding
//   o_busy       high while armed or holding a timestamp
// -----------------------------------------------------------------------------
module fine_tdc_decoder #(
  parameter int STAGES   = 12,
  parameter int COARSE_W = 16,
  parameter int FINE_W   = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [STAGES-1:0]   i_thermo,
  input  logic                i_arm,
  input  logic                i_ts_ready,
  output logic                o_ts_valid,
  output logic [COARSE_W-1:0] o_ts_coarse,
  output logic [FINE_W-1:0]   o_ts_fine,
  output logic                o_overflow,
  output logic                o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [COARSE_W-1:0] r_coarseCnt;

  logic [STAGES-1:0]   r_thermoQ;
  logic [COARSE_W-1:0] r_coarseQ;
  logic                r_prevBit0;

  logic [FINE_W-1:0]   r_fineP;
  logic [COARSE_W-1:0] r_coarseP;
  logic                r_hitP;

  logic                r_tsValid;
  logic [COARSE_W-1:0] r_tsCoarse;
  logic [FINE_W-1:0]   r_tsFine;
  logic                r_overflow;

  logic                w_hit;
  logic [STAGES+1:0]   w_thermoExt;
  logic [STAGES-1:0]   w_corr;
  logic [FINE_W-1:0]   w_fine;
  logic                w_handshake;
  logic                w_loadTs;
  logic                w_clearValid;
  logic                w_setOverflow;
  logic                w_clearOverflow;

  // Free-running coarse time base; wraps naturally at 2**COARSE_W.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_coarseCnt <= '0;
    end else begin
      r_coarseCnt <= r_coarseCnt + 1'b1;
    end
  end

  // First stage: register the delay-line word with the coarse count of the same
  // edge (pre-increment), and remember tap 0 of the previous sample for edge detect.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_thermoQ  <= '0;
      r_coarseQ  <= '0;
      r_prevBit0 <= 1'b0;
    end else begin
      r_thermoQ  <= i_thermo;
      r_coarseQ  <= r_coarseCnt;
      r_prevBit0 <= r_thermoQ[0];
    end
  end

  // A hit is the cycle in which the start edge first reaches tap 0.
  assign w_hit = r_thermoQ[0] & ~r_prevBit0;

  // Bubble removal: each tap takes the majority of itself and its neighbours.
  // Below tap 0 the line is treated as filled (1), above the last tap as empty (0),
  // so the ends of a clean thermometer code are left untouched.
  always_comb begin
    w_thermoExt = {1'b0, r_thermoQ, 1'b1};
    w_corr      = '0;
    for (int i = 0; i < STAGES; i++) begin
      w_corr[i] = (w_thermoExt[i]   & w_thermoExt[i+1]) |
                  (w_thermoExt[i]   & w_thermoExt[i+2]) |
                  (w_thermoExt[i+1] & w_thermoExt[i+2]);
    end
  end

  // Ones-count of the corrected word gives the fine code.
  always_comb begin
    w_fine = '0;
    for (int i = 0; i < STAGES; i++) begin
      w_fine = w_fine + FINE_W'(w_corr[i]);
    end
  end

  // Second stage: register the fine code, coarse value and hit flag together.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_fineP   <= '0;
      r_coarseP <= '0;
      r_hitP    <= 1'b0;
    end else begin
      r_fineP   <= w_fine;
      r_coarseP <= r_coarseQ;
      r_hitP    <= w_hit;
    end
  end

  // Capture FSM state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  assign w_handshake = r_tsValid & i_ts_ready;

  // Next-state logic. A handshake that coincides with a new hit keeps us in
  // HOLD so back-to-back timestamps flow without a bubble cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (i_arm) w_nextState = ARMED;
      end
      ARMED: begin
        if (r_hitP)      w_nextState = HOLD;
        else if (!i_arm) w_nextState = IDLE;
      end
      HOLD: begin
        if (w_handshake && !r_hitP) w_nextState = i_arm ? ARMED : IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Output decode: control strobes for the timestamp and overflow registers.
  always_comb begin
    w_loadTs        = 1'b0;
    w_clearValid    = 1'b0;
    w_setOverflow   = 1'b0;
    w_clearOverflow = 1'b0;
    case (r_state)
      IDLE: begin
        w_clearOverflow = i_arm;
      end
      ARMED: begin
        w_loadTs = r_hitP;
      end
      HOLD: begin
        w_loadTs      = w_handshake & r_hitP;
        w_clearValid  = w_handshake & ~r_hitP;
        w_setOverflow = ~w_handshake & r_hitP;
      end
      default: begin
        w_clearValid = 1'b1;
      end
    endcase
  end

  // Timestamp and overflow registers driven by the FSM strobes.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tsValid  <= 1'b0;
      r_tsCoarse <= '0;
      r_tsFine   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_loadTs) begin
        r_tsValid  <= 1'b1;
        r_tsCoarse <= r_coarseP;
        r_tsFine   <= r_fineP;
      end else if (w_clearValid) begin
        r_tsValid  <= 1'b0;
      end
      if (w_clearOverflow) begin
        r_overflow <= 1'b0;
      end else if (w_setOverflow) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_ts_valid  = r_tsValid;
  assign o_ts_coarse = r_tsCoarse;
  assign o_ts_fine   = r_tsFine;
  assign o_overflow  = r_overflow;
  assign o_busy      = (r_state != IDLE);

endmodule
